fir_decimator: RTL and testbench

Parametrised, time-multiplexed FIR filter with integer decimation and runtime-loadable coefficients. It is the successor to the fixed 31-tap, 1-bit-input audio filter. It uses one multiply-accumulate (MAC) unit that iterates over a circular sample buffer. It sits between the audio sample source (mic/PDM front end after conversion) and the downstream pitch/transcription pipeline, using a valid-pulse interface on both sides.

---
 rtl/fir_pkg.sv | 40 ++++
 rtl/fir_round_sat.sv | 18 +
 rtl/fir_decimator.sv | 139 +++++++++++++
 tb/tb_fir_decimator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR decimator.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Accumulator width that can hold NTAPS full-scale products without overflow.
    function automatic int acc_width(input int width, input int coeff_width, input int ntaps);
        return width + coeff_width + $clog2(ntaps);
    endfunction

    // Round half up, arithmetic shift right, then clamp to a signed width-bit range.
    // Works on a 64-bit container so callers sign-extend their accumulator into it.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                      input int shift,
                                                      input int width);
        logic signed [63:0] rounded;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (shift > 0) begin
            rounded = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        end else begin
            rounded = acc;
        end
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (rounded > hi) begin
            return hi;
        end else if (rounded < lo) begin
            return lo;
        end
        return rounded;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round/shift/saturate stage turning the MAC accumulator into an output sample.
// Latency: combinational, 0 cycles.
// Backpressure: none; result follows acc.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W = 37,
    parameter int WIDTH = 16,
    parameter int SHIFT = 10
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [WIDTH-1:0] result
);

    // The clamp guarantees the value fits WIDTH bits, so truncation is lossless.
    assign result = WIDTH'(sat_round(64'(acc), SHIFT, WIDTH));

endmodule

// File: rtl/fir_decimator.sv
// Time-multiplexed FIR with integer decimation: one MAC walks a circular sample buffer.
// Latency: NTAPS+2 cycles from accepted sample to sample_valid_out.
// Backpressure: none; samples arriving while busy are dropped and flag sticky overrun_out.
module fir_decimator
    import fir_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int NTAPS       = 31,
    parameter int DECIM       = 1,
    parameter int SHIFT       = 10
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic signed [WIDTH-1:0]    sample_in,
    input  logic                       sample_valid_in,
    input  logic                       coeff_wr_en_in,
    input  logic [$clog2(NTAPS)-1:0]   coeff_addr_in,
    input  logic signed [COEFF_WIDTH-1:0] coeff_data_in,
    output logic signed [WIDTH-1:0]    sample_out,
    output logic                       sample_valid_out,
    output logic                       busy_out,
    output logic                       overrun_out
);

    localparam int AW    = $clog2(NTAPS);
    localparam int DW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PW    = WIDTH + COEFF_WIDTH;
    localparam int ACC_W = acc_width(WIDTH, COEFF_WIDTH, NTAPS);

    state_t state;
    state_t state_nxt;

    logic signed [WIDTH-1:0]       smp_buf [NTAPS];
    logic signed [COEFF_WIDTH-1:0] coeff_q [NTAPS];
    logic [AW-1:0]                 wr_ptr;
    logic [AW-1:0]                 rd_ptr;
    logic [AW-1:0]                 tap;
    logic [DW-1:0]                 dec_cnt;
    logic signed [ACC_W-1:0]       acc;
    logic signed [PW-1:0]          prod;
    logic signed [WIDTH-1:0]       y_sat;
    logic                          accept;
    logic                          last_dec;
    logic                          last_tap;

    assign accept   = (state == IDLE) && sample_valid_in;
    assign last_dec = (dec_cnt == DW'(DECIM - 1));
    assign last_tap = (tap == AW'(NTAPS - 1));
    assign busy_out = (state != IDLE);

    // rd_ptr walks backwards from the newest sample, so tap k sees x[n-k].
    assign prod = PW'(smp_buf[rd_ptr]) * PW'(coeff_q[tap]);

    fir_round_sat #(
        .ACC_W (ACC_W),
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc    (acc),
        .result (y_sat)
    );

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start a MAC on the decimation boundary, run NTAPS taps, one OUT cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && last_dec) state_nxt = MAC;
            MAC:     if (last_tap) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Coefficient RAM: writable only while idle, deliberately left out of reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in && (state == IDLE) && coeff_wr_en_in && (int'(coeff_addr_in) < NTAPS)) begin
            coeff_q[coeff_addr_in] <= coeff_data_in;
        end
    end

    // Sample buffer, pointers, accumulator and output register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NTAPS; i++) begin
                smp_buf[i] <= '0;
            end
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            tap              <= '0;
            dec_cnt          <= '0;
            acc              <= '0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
            overrun_out      <= 1'b0;
        end else begin
            sample_valid_out <= 1'b0;
            if (sample_valid_in && (state != IDLE)) begin
                overrun_out <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_valid_in) begin
                        smp_buf[wr_ptr] <= sample_in;
                        wr_ptr <= (wr_ptr == AW'(NTAPS - 1)) ? '0 : wr_ptr + AW'(1);
                        rd_ptr <= wr_ptr;
                        if (last_dec) begin
                            dec_cnt <= '0;
                            acc     <= '0;
                            tap     <= '0;
                        end else begin
                            dec_cnt <= dec_cnt + DW'(1);
                        end
                    end
                end
                MAC: begin
                    acc    <= acc + ACC_W'(prod);
                    tap    <= tap + AW'(1);
                    rd_ptr <= (rd_ptr == '0) ? AW'(NTAPS - 1) : rd_ptr - AW'(1);
                end
                OUT: begin
                    sample_out       <= y_sat;
                    sample_valid_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_decimator.sv
// Bench for fir_decimator: two 4-tap instances (DECIM=1 and DECIM=2) against a sum-of-products model.
// Latency: expects each output NTAPS+2 = 6 cycles after the accepted sample.
// Backpressure: exercises dropped samples while busy and reset during a MAC.
module tb_fir_decimator;

    localparam int NT = 4;

    logic clk_in = 1'b0;
    logic rst_in;

    logic signed [15:0] sin  [2];
    logic               vin  [2];
    logic               wen  [2];
    logic [1:0]         wadr [2];
    logic signed [15:0] wdat [2];
    logic signed [15:0] sout [2];
    logic               vout [2];
    logic               busy [2];
    logic               ovr  [2];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: coefficient table and full history of accepted samples per instance.
    int coef  [2][NT];
    int hist  [2][256];
    int nacc  [2];
    int decim [2];

    always #5 clk_in = ~clk_in;

    fir_decimator #(.WIDTH(16), .COEFF_WIDTH(16), .NTAPS(NT), .DECIM(1), .SHIFT(10)) u_d1 (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .sample_in        (sin[0]),
        .sample_valid_in  (vin[0]),
        .coeff_wr_en_in   (wen[0]),
        .coeff_addr_in    (wadr[0]),
        .coeff_data_in    (wdat[0]),
        .sample_out       (sout[0]),
        .sample_valid_out (vout[0]),
        .busy_out         (busy[0]),
        .overrun_out      (ovr[0])
    );

    fir_decimator #(.WIDTH(16), .COEFF_WIDTH(16), .NTAPS(NT), .DECIM(2), .SHIFT(10)) u_d2 (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .sample_in        (sin[1]),
        .sample_valid_in  (vin[1]),
        .coeff_wr_en_in   (wen[1]),
        .coeff_addr_in    (wadr[1]),
        .coeff_data_in    (wdat[1]),
        .sample_out       (sout[1]),
        .sample_valid_out (vout[1]),
        .busy_out         (busy[1]),
        .overrun_out      (ovr[1])
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // y[n] = sum_k c[k]*x[n-k], missing history counts as zero; then round half up and clamp.
    function automatic longint model_out(input int d);
        longint a;
        longint q;
        longint y;
        int idx;
        a = 0;
        for (int k = 0; k < NT; k++) begin
            idx = nacc[d] - 1 - k;
            if (idx >= 0) a += longint'(coef[d][k]) * longint'(hist[d][idx]);
        end
        q = a + 512;
        if (q >= 0) y = q / 1024;
        else        y = -((-q + 1023) / 1024);
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    function automatic void model_reset();
        nacc[0] = 0;
        nacc[1] = 0;
    endfunction

    task automatic do_reset();
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        model_reset();
    endtask

    task automatic wcoef(input int d, input int a, input int v);
        @(posedge clk_in); #1;
        wen[d]  = 1'b1;
        wadr[d] = 2'(a);
        wdat[d] = 16'(v);
        @(posedge clk_in); #1;
        wen[d] = 1'b0;
        coef[d][a] = v;
    endtask

    // mode 0: plain sample; mode 1: also poke a sample and a coeff write two cycles later;
    // mode 2: assert reset two cycles after acceptance.
    task automatic send(input int d, input int x, input int mode);
        int     lat_v;
        int     nv;
        int     nb;
        longint got;
        longint exp_y;
        bit     exp_out;
        lat_v = 0; nv = 0; nb = 0; got = 0; exp_y = 0;
        @(posedge clk_in); #1;
        sin[d] = 16'(x);
        vin[d] = 1'b1;
        @(posedge clk_in); #1;
        vin[d] = 1'b0;
        hist[d][nacc[d]] = x;
        nacc[d]++;
        exp_out = (nacc[d] % decim[d]) == 0;
        if (exp_out) exp_y = model_out(d);
        if (mode == 2) begin
            model_reset();
            exp_out = 1'b0;
        end
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) begin
                @(posedge clk_in); #1;
            end
            if (busy[d]) nb++;
            if (vout[d]) begin
                nv++;
                if (lat_v == 0) begin
                    lat_v = c;
                    got   = sout[d];
                end
            end
            if (mode == 1 && c == 2) begin
                sin[d] = 16'sd7777; vin[d] = 1'b1;
                wen[d] = 1'b1; wadr[d] = 2'd0; wdat[d] = 16'sd5000;
            end
            if (mode == 1 && c == 3) begin
                vin[d] = 1'b0; wen[d] = 1'b0;
            end
            if (mode == 2 && c == 2) rst_in = 1'b1;
            if (mode == 2 && c == 3) rst_in = 1'b0;
        end
        if (mode == 2) begin
            chk("rst_no_valid", nv, 0);
            chk("rst_sample_out", sout[d], 0);
            chk("rst_valid_out", vout[d], 0);
            chk("rst_busy", busy[d], 0);
            chk("rst_overrun", ovr[d], 0);
        end else if (exp_out) begin
            chk($sformatf("d%0d_x%0d_latency", d, x), lat_v, 6);
            chk($sformatf("d%0d_x%0d_value", d, x), got, exp_y);
            chk($sformatf("d%0d_x%0d_valid_cycles", d, x), nv, 1);
            chk($sformatf("d%0d_x%0d_busy_cycles", d, x), nb, NT + 1);
        end else begin
            chk($sformatf("d%0d_x%0d_no_output", d, x), nv, 0);
            chk($sformatf("d%0d_x%0d_not_busy", d, x), nb, 0);
        end
        if (mode == 1) chk("overrun_set", ovr[d], 1);
    endtask

    initial begin
        rst_in = 1'b1;
        for (int d = 0; d < 2; d++) begin
            sin[d] = '0; vin[d] = 1'b0; wen[d] = 1'b0; wadr[d] = '0; wdat[d] = '0;
            for (int k = 0; k < NT; k++) coef[d][k] = 0;
        end
        decim[0] = 1;
        decim[1] = 2;
        model_reset();
        do_reset();

        // Reset state of both instances.
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_sample_out%0d", d), sout[d], 0);
            chk($sformatf("reset_valid%0d", d), vout[d], 0);
            chk($sformatf("reset_busy%0d", d), busy[d], 0);
            chk($sformatf("reset_overrun%0d", d), ovr[d], 0);
        end

        // Impulse response: expect 100, 200, -100, 0, 0.
        wcoef(0, 0, 1024); wcoef(0, 1, 2048); wcoef(0, 2, -1024); wcoef(0, 3, 0);
        send(0, 100, 0);
        for (int i = 0; i < 4; i++) send(0, 0, 0);

        // Rounding: 512 -> 1, -512 -> 0.
        wcoef(0, 0, 1); wcoef(0, 1, 0); wcoef(0, 2, 0);
        send(0, 512, 0);
        send(0, -512, 0);

        // Saturation at both rails.
        for (int k = 0; k < NT; k++) wcoef(0, k, 32767);
        for (int i = 0; i < NT; i++) send(0, 32767, 0);
        for (int i = 0; i < NT; i++) send(0, -32768, 0);

        // Decimation by 2: only the 2nd and 4th samples produce outputs.
        wcoef(1, 0, 1024); wcoef(1, 1, 0); wcoef(1, 2, 0); wcoef(1, 3, 0);
        send(1, 10, 0); send(1, 20, 0); send(1, 30, 0); send(1, 40, 0);

        // Wrap-around: output after input m is m-3 from a zeroed buffer.
        do_reset();
        wcoef(0, 0, 0); wcoef(0, 1, 0); wcoef(0, 2, 0); wcoef(0, 3, 1024);
        for (int m = 1; m <= 10; m++) send(0, m, 0);

        // Overrun: dropped sample and ignored coeff write must not leak into results.
        send(0, 50, 1);
        send(0, 60, 0);
        send(0, 70, 0);
        send(0, 80, 0);
        send(0, 90, 0);
        chk("overrun_sticky", ovr[0], 1);
        chk("overrun_other_instance", ovr[1], 0);

        // Random samples with random coefficients.
        for (int k = 0; k < NT; k++) wcoef(0, k, $urandom_range(0, 4095) - 2048);
        for (int i = 0; i < 6; i++) send(0, $urandom_range(0, 65535) - 32768, 0);

        // Reset mid-MAC, then the impulse response again from a cleared buffer.
        wcoef(0, 0, 1024); wcoef(0, 1, 2048); wcoef(0, 2, -1024); wcoef(0, 3, 0);
        send(0, 123, 2);
        send(0, 100, 0);
        for (int i = 0; i < 4; i++) send(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
